drawing_controller: RTL and testbench



---
 rtl/drawing_pkg.sv | 13 +
 rtl/drawing_controller.sv | 85 ++++++++
 tb/tb_drawing_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/drawing_pkg.sv
// drawing_pkg: state codes shared by the drawing controller and the datapath decode.
// Exports ST_* 4-bit codes (0..8) carried on drawing_controller.oState.
package drawing_pkg;
    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_MOVE        = 4'd1;
    localparam logic [3:0] ST_WAIT        = 4'd2;
    localparam logic [3:0] ST_CLEAN       = 4'd3;
    localparam logic [3:0] ST_DRAW        = 4'd4;
    localparam logic [3:0] ST_ERASE       = 4'd5;
    localparam logic [3:0] ST_CLEAR_WAIT  = 4'd6;
    localparam logic [3:0] ST_CLEAR       = 4'd7;
    localparam logic [3:0] ST_RESET_MOUSE = 4'd8;
endpackage

// File: rtl/drawing_controller.sv
// drawing_controller: sequencing FSM arbitrating mouse/keys for the cell-drawing datapath.
// Ports: iClk/iReset (sync, active-high); iDone/iMove from datapath; iDrawBtn/iEraseBtn
// mouse buttons; iClearKey/iMouseRstKey keys; oState datapath state code; oMouseReset
// mouse re-home strobe; oBusy high whenever not IDLE. All outputs registered.
module drawing_controller
    import drawing_pkg::*;
#(
    parameter bit CLEAR_ON_RESET   = 1'b1,
    parameter int MOUSE_RST_CYCLES = 16
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iDone,
    input  logic       iMove,
    input  logic       iDrawBtn,
    input  logic       iEraseBtn,
    input  logic       iClearKey,
    input  logic       iMouseRstKey,
    output logic [3:0] oState,
    output logic       oMouseReset,
    output logic       oBusy
);
    localparam int CW = ($clog2(MOUSE_RST_CYCLES + 1) > 5) ? $clog2(MOUSE_RST_CYCLES + 1) : 5;
    typedef enum logic [3:0] {
        S_IDLE, S_GAP, S_MOVE, S_WAIT, S_CLEAN, S_DRAW, S_ERASE, S_CLEAR_WAIT, S_CLEAR, S_RESET_MOUSE
    } state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_painted, r_boot;
    logic          w_draw_req, w_erase_req;
    logic [3:0]    w_code;
    always_comb begin
        w_draw_req  = iDrawBtn & ~iEraseBtn & ~r_painted;
        w_erase_req = iEraseBtn & ~iDrawBtn & ~r_painted;
        w_next      = r_state;
        case (r_state)
            S_IDLE:
                if (r_boot)                w_next = S_CLEAR;
                else if (iClearKey)        w_next = S_CLEAR_WAIT;
                else if (iMouseRstKey)     w_next = S_RESET_MOUSE;
                else if (iMove)            w_next = S_WAIT;
                else if (w_erase_req)      w_next = S_ERASE;
                else if (w_draw_req)       w_next = S_DRAW;
            S_GAP:                         w_next = S_MOVE;
            S_MOVE, S_DRAW, S_ERASE:       w_next = iDone ? S_IDLE : r_state;
            S_WAIT:                        w_next = S_CLEAN;
            S_CLEAN, S_CLEAR:              w_next = iDone ? S_GAP : r_state;
            S_CLEAR_WAIT:                  w_next = iClearKey ? S_CLEAR_WAIT : S_CLEAR;
            S_RESET_MOUSE:                 w_next = (r_cnt == CW'(MOUSE_RST_CYCLES - 1)) ? S_IDLE : S_RESET_MOUSE;
            default:                       w_next = S_IDLE;
        endcase
        case (w_next)
            S_MOVE:        w_code = ST_MOVE;
            S_WAIT:        w_code = ST_WAIT;
            S_CLEAN:       w_code = ST_CLEAN;
            S_DRAW:        w_code = ST_DRAW;
            S_ERASE:       w_code = ST_ERASE;
            S_CLEAR_WAIT:  w_code = ST_CLEAR_WAIT;
            S_CLEAR:       w_code = ST_CLEAR;
            S_RESET_MOUSE: w_code = ST_RESET_MOUSE;
            default:       w_code = ST_IDLE;
        endcase
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_painted   <= 1'b0;
            r_boot      <= CLEAR_ON_RESET;
            oState      <= ST_IDLE;
            oMouseReset <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_boot      <= 1'b0;
            r_cnt       <= (r_state == S_RESET_MOUSE && w_next == S_RESET_MOUSE) ? r_cnt + 1'b1 : '0;
            // one fill per cell per press: latched on fill exit, re-armed by a cell move or button release
            r_painted   <= ((r_state == S_DRAW || r_state == S_ERASE) && iDone) ? 1'b1 :
                           (w_next == S_WAIT || (r_state == S_IDLE && !iDrawBtn && !iEraseBtn)) ? 1'b0 : r_painted;
            oState      <= w_code;
            oMouseReset <= (w_next == S_RESET_MOUSE);
            oBusy       <= (w_next != S_IDLE);
        end
    end
endmodule

// File: tb/tb_drawing_controller.sv
// tb_drawing_controller: directed plus randomized self-checking bench for drawing_controller.
module tb_drawing_controller;
    logic       iClk = 1'b0, iReset = 1'b1, iDone = 1'b0, iMove = 1'b0;
    logic       iDrawBtn = 1'b0, iEraseBtn = 1'b0, iClearKey = 1'b0, iMouseRstKey = 1'b0;
    logic [3:0] oState;
    logic       oMouseReset, oBusy;
    int         total = 0, bad = 0;
    always #5 iClk = ~iClk;
    drawing_controller #(.CLEAR_ON_RESET(1'b1), .MOUSE_RST_CYCLES(16)) dut (
        .iClk(iClk), .iReset(iReset), .iDone(iDone), .iMove(iMove),
        .iDrawBtn(iDrawBtn), .iEraseBtn(iEraseBtn), .iClearKey(iClearKey),
        .iMouseRstKey(iMouseRstKey), .oState(oState), .oMouseReset(oMouseReset), .oBusy(oBusy)
    );
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic chk_out(input string tag, input int st, input bit busy, input bit mr);
        chk({tag, ".state"}, {4'd0, oState}, 8'(st));
        chk({tag, ".busy"}, {7'd0, oBusy}, {7'd0, busy});
        chk({tag, ".mrst"}, {7'd0, oMouseReset}, {7'd0, mr});
    endtask
    // GAP (code 0, busy) then MOVE until iDone, then IDLE
    task automatic finish_move(input string tag, input int d);
        chk_out({tag, "_gap"}, 0, 1, 0);
        iDone = 0;
        tick(); chk_out({tag, "_move"}, 1, 1, 0);
        for (int i = 1; i < d; i++) begin tick(); chk({tag, "_movehold"}, {4'd0, oState}, 8'd1); end
        iDone = 1;
        tick(); chk_out({tag, "_idle"}, 0, 0, 0);
        iDone = 0;
    endtask
    task automatic op_boot(input int d);
        chk_out("boot_idle", 0, 0, 0);
        tick(); chk_out("boot_clear", 7, 1, 0);
        for (int i = 1; i < d; i++) begin tick(); chk("boot_clearhold", {4'd0, oState}, 8'd7); end
        iDone = 1;
        tick(); finish_move("boot", 2);
    endtask
    task automatic op_fill(input bit erase, input int d, input int h);
        int code = erase ? 5 : 4;
        iDrawBtn = !erase; iEraseBtn = erase;
        tick(); chk_out("fill_enter", code, 1, 0);
        for (int i = 1; i < d; i++) begin tick(); chk("fill_hold", {4'd0, oState}, 8'(code)); end
        iDone = 1;
        tick(); chk_out("fill_exit", 0, 0, 0);
        for (int i = 0; i < h; i++) begin
            iDone = 1'($urandom_range(0, 1));
            tick(); chk("fill_once", {4'd0, oState}, 8'd0);
        end
        iDone = 0; iDrawBtn = 0; iEraseBtn = 0;
        tick(); chk("fill_release", {4'd0, oState}, 8'd0);
    endtask
    task automatic op_move(input int d1, input int d2);
        iMove = 1;
        tick(); chk_out("mv_wait", 2, 1, 0);
        iMove = 0;
        tick(); chk("mv_clean", {4'd0, oState}, 8'd3);
        for (int i = 1; i < d1; i++) begin tick(); chk("mv_cleanhold", {4'd0, oState}, 8'd3); end
        iDone = 1;
        tick(); finish_move("mv", d2);
    endtask
    task automatic op_clear(input int hold, input int d);
        iClearKey = 1;
        tick(); chk_out("clr_wait", 6, 1, 0);
        for (int i = 1; i < hold; i++) begin tick(); chk("clr_waithold", {4'd0, oState}, 8'd6); end
        iClearKey = 0;
        tick(); chk("clr_clear", {4'd0, oState}, 8'd7);
        for (int i = 1; i < d; i++) begin tick(); chk("clr_clearhold", {4'd0, oState}, 8'd7); end
        iDone = 1;
        tick(); finish_move("clr", 3);
    endtask
    task automatic op_mrst();
        iMouseRstKey = 1;
        tick(); chk_out("mr_enter", 8, 1, 1);
        iMouseRstKey = 0;
        for (int i = 1; i < 16; i++) begin tick(); chk_out("mr_hold", 8, 1, 1); end
        tick(); chk_out("mr_exit", 0, 0, 0);
    endtask
    initial begin
        tick(); tick();
        chk_out("reset", 0, 0, 0);
        iReset = 0;
        op_boot(10);
        op_move(4, 3);
        op_fill(0, 10, 189);
        op_fill(0, 3, 5);
        iDrawBtn = 1; iEraseBtn = 1;
        for (int i = 0; i < 5; i++) begin tick(); chk_out("both_btn", 0, 0, 0); end
        iDrawBtn = 0;
        op_move(2, 2);
        tick(); chk_out("pending_erase", 5, 1, 0);
        iDone = 1;
        tick(); chk("pending_erase_exit", {4'd0, oState}, 8'd0);
        iDone = 0; iEraseBtn = 0;
        tick(); chk("pending_erase_rel", {4'd0, oState}, 8'd0);
        op_clear(50, 6);
        op_mrst();
        iMouseRstKey = 1;
        tick(); chk_out("mr2_enter", 8, 1, 1);
        iMouseRstKey = 0;
        for (int i = 2; i < 5; i++) tick();
        iReset = 1;
        tick(); chk_out("mid_reset", 0, 0, 0);
        iReset = 0;
        op_boot(3);
        for (int n = 0; n < 14; n++) begin
            int gap = $urandom_range(0, 4);
            for (int i = 0; i < gap; i++) begin
                iDone = 1'($urandom_range(0, 1));
                tick(); chk_out("idle_noise", 0, 0, 0);
            end
            iDone = 0;
            case ($urandom_range(0, 4))
                0: op_fill(0, $urandom_range(1, 12), $urandom_range(0, 8));
                1: op_fill(1, $urandom_range(1, 12), $urandom_range(0, 8));
                2: op_move($urandom_range(1, 12), $urandom_range(1, 12));
                3: op_clear($urandom_range(1, 10), $urandom_range(1, 12));
                default: op_mrst();
            endcase
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
